pic_cmd_sequencer: RTL and testbench



---
 rtl/pic_cmd_sequencer_if.sv | 36 +++
 rtl/pic_cmd_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pic_cmd_sequencer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pic_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// pic_cmd_sequencer_if
// Byte stream between the PIC command sequencer (master) and the PIC MCU byte
// serializer (slave).
//
// Signals:
//   byte_data  [7:0]  command byte, driven by the master
//   byte_valid        byte_data is valid, driven by the master
//   frame_last        byte_data is the final byte of its frame, driven by master
//   byte_ready        serializer can take byte_data, driven by the slave
//
// Handshake: a byte moves on every rising clock edge where byte_valid and
// byte_ready are both high. Once byte_valid is raised, byte_data and
// frame_last hold steady until that transfer; byte_valid never depends
// combinationally on byte_ready.
// -----------------------------------------------------------------------------
interface pic_cmd_sequencer_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       frame_last;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        output frame_last,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        input  frame_last,
        output byte_ready
    );
endinterface

// File: rtl/pic_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// pic_cmd_sequencer
// Decides which command frame the PIC MCU serializer sends next. It debounces
// PTT, tracks IP address changes and bootloader requests, picks one source by
// priority (PTT > boot > IP), and streams the frame one byte at a time. Frames
// are separated by an enforced idle gap.
//
// Ports:
//   clock, reset   80 kHz clock, synchronous active-high reset
//   PTT_in         raw PTT level, already synchronised to clock
//   ip_addr[31:0]  IP address, IP1 = [31:24] .. IP4 = [7:0]
//   ip_valid       ip_addr is valid this cycle
//   boot_req       single-cycle bootloader request
//   byte_if        byte stream to the serializer (master side)
//   busy           FSM is not in IDLE
//   ptt_state      debounced PTT level
//   dbg_state_o    current FSM state (IDLE=0, LOAD=1, SEND=2, GAP=3)
// -----------------------------------------------------------------------------
module pic_cmd_sequencer #(
    parameter int DEBOUNCE_CYCLES = 400,
    parameter int GAP_CYCLES      = 80
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       PTT_in,
    input  logic [31:0]                ip_addr,
    input  logic                       ip_valid,
    input  logic                       boot_req,
    pic_cmd_sequencer_if.master        byte_if,
    output logic                       busy,
    output logic                       ptt_state,
    output logic [1:0]                 dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t        state_q;
    logic [DW-1:0] deb_cnt_q;
    logic [GW-1:0] gap_cnt_q;
    logic          ptt_state_q;
    logic          ptt_sent_q;
    logic [31:0]   last_ip_q;
    logic          ip_pend_q;
    logic          boot_pend_q;
    logic [7:0]    frame_buf_q [5];
    logic [2:0]    len_q;
    logic [2:0]    idx_q;
    logic [7:0]    byte_data_q;
    logic          byte_valid_q;
    logic          frame_last_q;

    logic ptt_pend;
    logic any_pend;
    logic load_ptt;
    logic load_boot;
    logic load_ip;
    logic ip_set;

    // Source selection. PTT pending is derived, so a PTT that returns to its
    // last-sent level before being served simply stops being pending.
    always_comb begin
        ptt_pend  = (ptt_state_q != ptt_sent_q);
        any_pend  = ptt_pend | boot_pend_q | ip_pend_q;
        load_ptt  = (state_q == S_LOAD) && ptt_pend;
        load_boot = (state_q == S_LOAD) && !ptt_pend && boot_pend_q;
        load_ip   = (state_q == S_LOAD) && !ptt_pend && !boot_pend_q && ip_pend_q;
        ip_set    = ip_valid && (ip_addr != last_ip_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            deb_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            ptt_state_q  <= 1'b0;
            ptt_sent_q   <= 1'b0;
            last_ip_q    <= '0;
            ip_pend_q    <= 1'b0;
            boot_pend_q  <= 1'b0;
            for (int i = 0; i < 5; i++) frame_buf_q[i] <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_last_q <= 1'b0;
        end else begin
            // Debounce: any sample matching the current state restarts the count.
            if (PTT_in == ptt_state_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                ptt_state_q <= PTT_in;
                deb_cnt_q   <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DW'(1);
            end

            if (ip_valid) last_ip_q <= ip_addr;

            // A new request on the same edge as its LOAD wins over the clear.
            ip_pend_q   <= ip_set | (ip_pend_q & ~load_ip);
            boot_pend_q <= boot_req | (boot_pend_q & ~load_boot);

            case (state_q)
                S_IDLE: begin
                    if (any_pend) state_q <= S_LOAD;
                end

                S_LOAD: begin
                    idx_q        <= '0;
                    byte_valid_q <= 1'b1;
                    state_q      <= S_SEND;
                    if (load_ptt) begin
                        ptt_sent_q     <= ptt_state_q;
                        frame_buf_q[0] <= ptt_state_q ? 8'h05 : 8'h06;
                        byte_data_q    <= ptt_state_q ? 8'h05 : 8'h06;
                        len_q          <= 3'd1;
                        frame_last_q   <= 1'b1;
                    end else if (load_boot) begin
                        frame_buf_q[0] <= 8'h04;
                        byte_data_q    <= 8'h04;
                        len_q          <= 3'd1;
                        frame_last_q   <= 1'b1;
                    end else if (load_ip) begin
                        // Snapshot of the address as it stands now; later
                        // changes go out as a separate frame.
                        frame_buf_q[0] <= 8'h03;
                        frame_buf_q[1] <= last_ip_q[31:24];
                        frame_buf_q[2] <= last_ip_q[23:16];
                        frame_buf_q[3] <= last_ip_q[15:8];
                        frame_buf_q[4] <= last_ip_q[7:0];
                        byte_data_q    <= 8'h03;
                        len_q          <= 3'd5;
                        frame_last_q   <= 1'b0;
                    end else begin
                        byte_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end

                S_SEND: begin
                    if (byte_if.byte_ready) begin
                        if (frame_last_q) begin
                            byte_valid_q <= 1'b0;
                            frame_last_q <= 1'b0;
                            byte_data_q  <= '0;
                            gap_cnt_q    <= '0;
                            state_q      <= S_GAP;
                        end else begin
                            // Next byte follows with no bubble.
                            idx_q        <= idx_q + 3'd1;
                            byte_data_q  <= frame_buf_q[idx_q + 3'd1];
                            frame_last_q <= ((idx_q + 3'd2) == len_q);
                        end
                    end
                end

                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_if.byte_data  = byte_data_q;
    assign byte_if.byte_valid = byte_valid_q;
    assign byte_if.frame_last = frame_last_q;
    assign busy               = (state_q != S_IDLE);
    assign ptt_state          = ptt_state_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pic_cmd_sequencer
// Bench for pic_cmd_sequencer: reset values, debounce timing, frame contents
// and ordering, handshake stalls, inter-frame gap, reset mid-frame, and a
// randomized event phase predicted by a frame-level model.
// -----------------------------------------------------------------------------
module tb_pic_cmd_sequencer;

    localparam int DEB = 400;
    localparam int GAP = 80;

    // ---------------- clock / reset ----------------
    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        PTT_in   = 1'b0;
    logic [31:0] ip_addr  = '0;
    logic        ip_valid = 1'b0;
    logic        boot_req = 1'b0;
    logic        busy;
    logic        ptt_state;
    logic [1:0]  dbg_state;

    pic_cmd_sequencer_if byte_if();

    pic_cmd_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .PTT_in     (PTT_in),
        .ip_addr    (ip_addr),
        .ip_valid   (ip_valid),
        .boot_req   (boot_req),
        .byte_if    (byte_if),
        .busy       (busy),
        .ptt_state  (ptt_state),
        .dbg_state_o(dbg_state)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // ---------------- bookkeeping ----------------
    int          total = 0;
    int          bad   = 0;
    int          ready_mode = 0;      // 0: always ready, 1: random, 2: stalled
    logic [8:0]  exp_q[$];            // {frame_last, byte}
    int          xfer_cnt = 0;
    int          frame_cnt = 0;
    int          last_xfer_cyc = 0;
    int          frame_start_cyc = 0;
    int          last_frame_cycles = 0;
    bit          have_last = 0;
    bit          in_frame = 0;
    bit          prev_hold = 0;
    bit          valid_seen = 0;
    logic [7:0]  prev_data = '0;
    logic        prev_last = 1'b0;
    logic [31:0] model_last_ip = '0;

    typedef struct {
        logic [31:0] addr;
        logic        boot;
        int          exp_bytes;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_event(input logic [31:0] a, input bit do_ip, input bit do_boot);
        tick();
        ip_addr  = a;
        ip_valid = do_ip;
        boot_req = do_boot;
        tick();
        ip_valid = 1'b0;
        boot_req = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        repeat (2) tick();
        exp_q.delete();
        model_last_ip = '0;
        reset = 1'b0;
    endtask

    // ---------------- reference model (frame level) ----------------
    task automatic push_ip(input logic [31:0] a);
        exp_q.push_back({1'b0, 8'h03});
        exp_q.push_back({1'b0, a[31:24]});
        exp_q.push_back({1'b0, a[23:16]});
        exp_q.push_back({1'b0, a[15:8]});
        exp_q.push_back({1'b1, a[7:0]});
    endtask

    // Boot outranks IP when both are raised together.
    task automatic model_event(input logic [31:0] a, input bit do_ip, input bit do_boot);
        if (do_boot) exp_q.push_back({1'b1, 8'h04});
        if (do_ip && (a != model_last_ip)) push_ip(a);
        if (do_ip) model_last_ip = a;
    endtask

    task automatic wait_quiet(input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 4000) begin
            @(negedge clock);
            n++;
            if (!busy && !byte_if.byte_valid && exp_q.size() == 0) quiet++;
            else quiet = 0;
        end
        total++;
        if (quiet < 3) begin
            bad++;
            $display("FAIL %s timeout act_pending=%0d exp_pending=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- ready driver ----------------
    initial begin
        byte_if.byte_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       byte_if.byte_ready = 1'b1;
                1:       byte_if.byte_ready = 1'($urandom_range(0, 1));
                default: byte_if.byte_ready = 1'b0;
            endcase
        end
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clock) begin
        if (reset) begin
            prev_hold = 0;
            in_frame  = 0;
            have_last = 0;
        end else begin
            if (prev_hold)
                chk("hold_stable",
                    {22'b0, byte_if.byte_valid, byte_if.frame_last, byte_if.byte_data},
                    {22'b0, 1'b1, prev_last, prev_data});
            if (!byte_if.byte_valid) begin
                chk("idle_zero", {23'b0, byte_if.frame_last, byte_if.byte_data}, 32'd0);
            end else begin
                valid_seen = 1;
                if (!in_frame) begin
                    in_frame = 1;
                    frame_start_cyc = cyc;
                    if (have_last) begin
                        total++;
                        if (cyc - last_xfer_cyc - 1 < GAP + 2) begin
                            bad++;
                            $display("FAIL gap act=%0d min=%0d", cyc - last_xfer_cyc - 1, GAP + 2);
                        end
                    end
                end
                if (byte_if.byte_ready) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte act=%h exp=none", {byte_if.frame_last, byte_if.byte_data});
                    end else begin
                        chk("byte", {23'b0, byte_if.frame_last, byte_if.byte_data},
                            {23'b0, exp_q.pop_front()});
                    end
                    if (byte_if.frame_last) begin
                        frame_cnt++;
                        last_xfer_cyc     = cyc;
                        last_frame_cycles = cyc - frame_start_cyc + 1;
                        have_last         = 1;
                        in_frame          = 0;
                    end
                end
            end
            prev_hold = byte_if.byte_valid && !byte_if.byte_ready;
            prev_data = byte_if.byte_data;
            prev_last = byte_if.frame_last;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog act=running exp=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        int fc0;
        int x0;
        int t;
        bit found;

        tbl[0] = '{32'hC0A8_0164, 1'b0, 5};
        tbl[1] = '{32'hC0A8_0164, 1'b0, 0};
        tbl[2] = '{32'h0A00_0001, 1'b0, 5};
        tbl[3] = '{32'h0A00_0001, 1'b1, 1};
        tbl[4] = '{32'h0000_0000, 1'b0, 5};
        tbl[5] = '{32'h0000_0000, 1'b0, 0};
        tbl[6] = '{32'hFFFF_FFFF, 1'b1, 6};
        tbl[7] = '{32'hFFFF_FFFF, 1'b1, 1};

        // Reset values
        repeat (3) tick();
        @(negedge clock);
        chk("rst_data",  {24'b0, byte_if.byte_data}, 32'd0);
        chk("rst_valid", {31'b0, byte_if.byte_valid}, 32'd0);
        chk("rst_last",  {31'b0, byte_if.frame_last}, 32'd0);
        chk("rst_busy",  {31'b0, busy}, 32'd0);
        chk("rst_ptt",   {31'b0, ptt_state}, 32'd0);
        tick();
        reset = 1'b0;

        // 1: PTT rise debounced at exactly DEB cycles, then one 0x05 frame
        tick();
        PTT_in = 1'b1;
        exp_q.push_back({1'b1, 8'h05});
        fc0 = frame_cnt;
        repeat (DEB - 1) @(posedge clock);
        @(negedge clock);
        chk("t1_ptt_before", {31'b0, ptt_state}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        chk("t1_ptt_after", {31'b0, ptt_state}, 32'd1);
        n = 0;
        while (frame_cnt == fc0 && n < 2000) begin
            @(posedge clock);
            n++;
        end
        chk("t1_frames", frame_cnt - fc0, 32'd1);
        t = last_xfer_cyc;
        while (cyc < t + GAP) @(negedge clock);
        chk("t1_busy_gap_end", {31'b0, busy}, 32'd1);
        @(negedge clock);
        chk("t1_busy_fall", {31'b0, busy}, 32'd0);
        wait_quiet("t1_quiet");

        // 2a: glitch one cycle too short never changes ptt_state
        PTT_in = 1'b0;
        do_reset();
        valid_seen = 0;
        tick();
        PTT_in = 1'b1;
        repeat (DEB - 1) tick();
        PTT_in = 1'b0;
        repeat (5) tick();
        @(negedge clock);
        chk("t2_glitch_ptt", {31'b0, ptt_state}, 32'd0);
        repeat (20) tick();
        chk("t2_no_valid", {31'b0, valid_seen}, 32'd0);

        // 2b: PTT up and back down while an IP frame is stalled -> no PTT frame
        drive_event(32'h0102_0304, 1'b1, 1'b0);
        model_event(32'h0102_0304, 1'b1, 1'b0);
        fc0 = frame_cnt;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (byte_if.byte_valid) found = 1;
        end
        chk("t2_ip_started", {31'b0, found}, 32'd1);
        ready_mode = 2;
        tick();
        PTT_in = 1'b1;
        repeat (DEB + 50) tick();
        @(negedge clock);
        chk("t2_ptt_high", {31'b0, ptt_state}, 32'd1);
        chk("t2_stalled_valid", {31'b0, byte_if.byte_valid}, 32'd1);
        tick();
        PTT_in = 1'b0;
        repeat (DEB + 50) tick();
        @(negedge clock);
        chk("t2_ptt_low", {31'b0, ptt_state}, 32'd0);
        ready_mode = 0;
        wait_quiet("t2_quiet");
        chk("t2_frames", frame_cnt - fc0, 32'd1);

        // 3: table-driven IP / boot vectors
        for (int i = 0; i < 8; i++) begin
            x0 = xfer_cnt;
            drive_event(tbl[i].addr, 1'b1, tbl[i].boot);
            model_event(tbl[i].addr, 1'b1, tbl[i].boot);
            wait_quiet("tbl_quiet");
            chk("tbl_bytes", xfer_cnt - x0, tbl[i].exp_bytes);
            if (tbl[i].exp_bytes != 0)
                chk("tbl_consec", last_frame_cycles, (tbl[i].exp_bytes > 1) ? 5 : 1);
        end

        // 4: PTT rise, boot and new IP on the same edge -> 05, 04, IP
        tick();
        PTT_in = 1'b1;
        repeat (DEB - 1) tick();
        ip_addr  = 32'h1122_3344;
        ip_valid = 1'b1;
        boot_req = 1'b1;
        tick();
        ip_valid = 1'b0;
        boot_req = 1'b0;
        exp_q.push_back({1'b1, 8'h05});
        model_event(32'h1122_3344, 1'b1, 1'b1);
        fc0 = frame_cnt;
        wait_quiet("t4_quiet");
        chk("t4_frames", frame_cnt - fc0, 32'd3);
        PTT_in = 1'b0;
        exp_q.push_back({1'b1, 8'h06});
        wait_quiet("t4_ptt_off");

        // 5: stall 10 cycles on byte 2 of an IP frame
        drive_event(32'hC0A8_0164, 1'b1, 1'b0);
        model_event(32'hC0A8_0164, 1'b1, 1'b0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (byte_if.byte_valid && byte_if.byte_data == 8'hC0) found = 1;
        end
        chk("t5_found_c0", {31'b0, found}, 32'd1);
        ready_mode = 2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t5_hold", {23'b0, byte_if.byte_valid, byte_if.frame_last, byte_if.byte_data},
                {23'b0, 1'b1, 1'b0, 8'hA8});
        end
        ready_mode = 0;
        wait_quiet("t5_quiet");

        // 6: reset at byte 3 of an IP frame; same address resent afterwards
        drive_event(32'h0A0B_0C0D, 1'b1, 1'b0);
        model_event(32'h0A0B_0C0D, 1'b1, 1'b0);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (byte_if.byte_valid && byte_if.byte_data == 8'h0B) found = 1;
        end
        chk("t6_found_0b", {31'b0, found}, 32'd1);
        tick();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("t6_valid", {31'b0, byte_if.byte_valid}, 32'd0);
        chk("t6_busy",  {31'b0, busy}, 32'd0);
        chk("t6_data",  {24'b0, byte_if.byte_data}, 32'd0);
        chk("t6_last",  {31'b0, byte_if.frame_last}, 32'd0);
        exp_q.delete();
        model_last_ip = '0;
        tick();
        reset = 1'b0;
        x0 = xfer_cnt;
        drive_event(32'h0A0B_0C0D, 1'b1, 1'b0);
        model_event(32'h0A0B_0C0D, 1'b1, 1'b0);
        wait_quiet("t6_quiet");
        chk("t6_resend_bytes", xfer_cnt - x0, 32'd5);

        // Random events with random back-pressure
        ready_mode = 1;
        for (int i = 0; i < 30; i++) begin
            int          kind;
            int          len;
            logic [31:0] a;
            kind = $urandom_range(0, 4);
            a    = $urandom;
            case (kind)
                0: begin
                    drive_event(a, 1'b1, 1'b0);
                    model_event(a, 1'b1, 1'b0);
                end
                1: begin
                    drive_event(model_last_ip, 1'b1, 1'b0);
                    model_event(model_last_ip, 1'b1, 1'b0);
                end
                2: begin
                    drive_event(a, 1'b0, 1'b1);
                    model_event(a, 1'b0, 1'b1);
                end
                3: begin
                    len = ($urandom_range(0, 1) == 1) ? $urandom_range(100, DEB - 1)
                                                      : $urandom_range(DEB, DEB + 40);
                    tick();
                    PTT_in = 1'b1;
                    if (len >= DEB) exp_q.push_back({1'b1, 8'h05});
                    repeat (len) tick();
                    PTT_in = 1'b0;
                    if (len >= DEB) exp_q.push_back({1'b1, 8'h06});
                end
                default: begin
                    drive_event(a, 1'b1, 1'b1);
                    model_event(a, 1'b1, 1'b1);
                end
            endcase
            wait_quiet("rand_quiet");
        end
        ready_mode = 0;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
